// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter
//   Shares one WIDTH-bit bitwise logic unit (AND/OR/XOR/NOR) between two
//   valid/ready requesters. A round-robin arbiter picks one request per cycle.
//   The result goes into a single output register that the consumer drains
//   with a valid/ready handshake.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   reqN_valid/ready            requester N handshake (N = 0, 1)
//   reqN_op                     00 AND, 01 OR, 10 XOR, 11 NOR
//   reqN_x, reqN_y              operands
//   res_valid/ready             result handshake toward the consumer
//   res_data                    result
//   res_id                      index of the requester that produced res_data
//   res_zero                    res_data == 0 (only with LU_ZERO_FLAG_EN)
//
// Build option
//   LU_ZERO_FLAG_EN             adds the registered res_zero flag
module logic_unit_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_x,
  input  logic [WIDTH-1:0] req0_y,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_x,
  input  logic [WIDTH-1:0] req1_y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
`ifdef LU_ZERO_FLAG_EN
  output logic             res_zero,
`endif
  output logic             res_id
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state, state_n;

  logic             last;
  logic             can_accept;
  logic             gnt_vld_p0;
  logic             gnt_id_p0;
  logic             xfer_p0;
  logic [1:0]       op_p0;
  logic [WIDTH-1:0] x_p0;
  logic [WIDTH-1:0] y_p0;
  logic [WIDTH-1:0] result_p0;

  logic [WIDTH-1:0] data_p1;
  logic             id_p1;

  function automatic logic [WIDTH-1:0] lu_op(input logic [1:0]       op,
                                             input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    case (op)
      2'b00:   r = x & y;
      2'b01:   r = x | y;
      2'b10:   r = x ^ y;
      default: r = ~(x | y);
    endcase
    return r;
  endfunction

  // ---- stage p0: arbitration and logic op ----
  assign can_accept = (state == EMPTY) || res_ready;

  always_comb begin
    gnt_vld_p0 = 1'b0;
    gnt_id_p0  = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt_vld_p0 = 1'b1;
      gnt_id_p0  = ~last;           // tie goes to whoever did not win last
    end else if (req0_valid) begin
      gnt_vld_p0 = 1'b1;
      gnt_id_p0  = 1'b0;
    end else if (req1_valid) begin
      gnt_vld_p0 = 1'b1;
      gnt_id_p0  = 1'b1;
    end
  end

  // No transfer is offered while reset is asserted.
  assign xfer_p0    = gnt_vld_p0 && can_accept && !rst;
  assign req0_ready = xfer_p0 && !gnt_id_p0;
  assign req1_ready = xfer_p0 &&  gnt_id_p0;

  assign op_p0     = gnt_id_p0 ? req1_op : req0_op;
  assign x_p0      = gnt_id_p0 ? req1_x  : req0_x;
  assign y_p0      = gnt_id_p0 ? req1_y  : req0_y;
  assign result_p0 = lu_op(op_p0, x_p0, y_p0);

  always_comb begin
    state_n = state;
    case (state)
      EMPTY: if (xfer_p0) state_n = FULL;
      FULL: begin
        if (xfer_p0)        state_n = FULL;   // drain and reload together
        else if (res_ready) state_n = EMPTY;
      end
      default: state_n = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      last  <= 1'b1;
    end else begin
      state <= state_n;
      if (xfer_p0) last <= gnt_id_p0;
    end
  end

  // ---- stage p1: output register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p1 <= '0;
      id_p1   <= 1'b0;
    end else if (xfer_p0) begin
      data_p1 <= result_p0;
      id_p1   <= gnt_id_p0;
    end
  end

`ifdef LU_ZERO_FLAG_EN
  logic zero_p1;

  // Flag is taken from the value being loaded, not the stale register.
  always_ff @(posedge clk) begin
    if (rst)          zero_p1 <= 1'b0;
    else if (xfer_p0) zero_p1 <= (result_p0 == '0);
  end

  assign res_zero = zero_p1;
`endif

  assign res_valid = (state == FULL);
  assign res_data  = data_p1;
  assign res_id    = id_p1;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
module tb_logic_unit_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [1:0]   req0_op, req1_op;
  logic [W-1:0] req0_x, req0_y, req1_x, req1_y;
  logic         res_valid, res_ready, res_id;
  logic [W-1:0] res_data;
`ifdef LU_ZERO_FLAG_EN
  logic         res_zero;
`endif

  logic_unit_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_x(req0_x), .req0_y(req0_y),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_x(req1_x), .req1_y(req1_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
`ifdef LU_ZERO_FLAG_EN
    .res_zero(res_zero),
`endif
    .res_id(res_id)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  // Reference model state
  bit         m_vld;
  bit [W-1:0] m_data;
  bit         m_id;
  bit         m_last;
  bit         m_zero;
  bit         e0, e1;      // expected readies of the most recent cycle

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit [W-1:0] ref_op(input bit [1:0] op, input bit [W-1:0] x, input bit [W-1:0] y);
    case (op)
      2'd0:    return x & y;
      2'd1:    return x | y;
      2'd2:    return x ^ y;
      default: return ~(x | y);
    endcase
  endfunction

  task automatic set0(input bit v, input bit [1:0] op, input bit [W-1:0] x, input bit [W-1:0] y);
    req0_valid = v; req0_op = op; req0_x = x; req0_y = y;
  endtask

  task automatic set1(input bit v, input bit [1:0] op, input bit [W-1:0] x, input bit [W-1:0] y);
    req1_valid = v; req1_op = op; req1_x = x; req1_y = y;
  endtask

  // One clock: check readies against the model, step the model, check outputs.
  task automatic cycle();
    bit space;
    int winner;
    #1;
    space  = !m_vld || res_ready;
    winner = -1;
    if (req0_valid && req1_valid) winner = m_last ? 0 : 1;
    else if (req0_valid)          winner = 0;
    else if (req1_valid)          winner = 1;
    e0 = !rst && space && (winner == 0);
    e1 = !rst && space && (winner == 1);
    chk("req0_ready", req0_ready, e0);
    chk("req1_ready", req1_ready, e1);
    @(posedge clk);
    if (rst) begin
      m_vld = 0; m_data = '0; m_id = 0; m_last = 1; m_zero = 0;
    end else if (e0 || e1) begin
      m_data = e0 ? ref_op(req0_op, req0_x, req0_y) : ref_op(req1_op, req1_x, req1_y);
      m_id   = e1;
      m_last = e1;
      m_vld  = 1;
      m_zero = (m_data == '0);
    end else if (res_ready) begin
      m_vld = 0;
    end
    #1;
    chk("res_valid", res_valid, m_vld);
    chk("res_data", res_data, m_data);
    chk("res_id", res_id, m_id);
`ifdef LU_ZERO_FLAG_EN
    chk("res_zero", res_zero, m_zero);
`endif
  endtask

  task automatic do_reset(input int n);
    rst = 1;
    for (int i = 0; i < n; i++) cycle();
    rst = 0;
  endtask

  initial begin
    rst = 1; res_ready = 1;
    set0(0, 0, '0, '0);
    set1(0, 0, '0, '0);
    m_vld = 0; m_data = '0; m_id = 0; m_last = 1; m_zero = 0;
    @(posedge clk); #1;

    // Reset then single request
    do_reset(2);
    chk("rst_valid", res_valid, 0);
    chk("rst_data", res_data, 0);
    chk("rst_id", res_id, 0);
    set0(1, 2'b10, 32'hFFFF0000, 32'h0F0F0F0F);
    cycle();
    chk("single_ready0", e0, 1);
    chk("single_data", res_data, 32'hF0F00F0F);
    chk("single_id", res_id, 0);
    set0(0, 0, '0, '0);
    cycle();

    // Tie and alternation from reset
    do_reset(1);
    set0(1, 2'b00, 32'hAAAAAAAA, 32'hAAAAAAAA);
    set1(1, 2'b11, 32'h0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("tie_id", res_id, i % 2);
      chk("tie_data", res_data, (i % 2) ? 32'hFFFFFFFF : 32'hAAAAAAAA);
    end
    set0(0, 0, '0, '0);
    set1(0, 0, '0, '0);
    cycle();

    // Backpressure
    res_ready = 0;
    set1(1, 2'b01, 32'h1, 32'h2);
    cycle();
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_ready1", req1_ready, 0);
      chk("bp_data", res_data, 32'h3);
    end
    res_ready = 1;
    cycle();
    chk("bp_release", e1, 1);
    set1(0, 0, '0, '0);
    cycle();

    // Stalled tie keeps winner: make req0 the last winner with output full
    res_ready = 0;
    set0(1, 2'b00, 32'hF0, 32'hFF);
    cycle();
    set1(1, 2'b01, 32'h10, 32'h01);
    for (int i = 0; i < 4; i++) cycle();
    res_ready = 1;
    cycle();
    chk("stall_tie_id", res_id, 1);
    chk("stall_tie_data", res_data, 32'h11);

    // Reset mid-operation
    res_ready = 0;
    cycle();
    do_reset(1);
    chk("midrst_valid", res_valid, 0);
    chk("midrst_data", res_data, 0);
    res_ready = 1;
    cycle();
    chk("midrst_tie", res_id, 0);
    set0(0, 0, '0, '0);
    set1(0, 0, '0, '0);
    cycle();

`ifdef LU_ZERO_FLAG_EN
    set0(1, 2'b10, 32'h12345678, 32'h12345678);
    cycle();
    chk("zf_data", res_data, 0);
    chk("zf_set", res_zero, 1);
    set0(1, 2'b01, 32'h0, 32'h1);
    cycle();
    chk("zf_clear", res_zero, 0);
    set0(0, 0, '0, '0);
    cycle();
`endif

    // Randomized traffic; operands are held while a request waits
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      res_ready = ($urandom_range(0, 9) < 7);
      if (!(req0_valid && !e0)) begin
        set0($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom, $urandom);
        if ($urandom_range(0, 7) == 0) req0_y = req0_x;
      end
      if (!(req1_valid && !e1)) begin
        set1($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom, $urandom);
        if ($urandom_range(0, 7) == 0) req1_y = req1_x;
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Shares one WIDTH-bit bitwise logic unit (AND/OR/XOR/NOR) between two requesters.
- Each requester uses a valid/ready handshake. A round-robin arbiter picks one request per cycle.
- The result is held in a single output register with valid/ready backpressure toward the consumer.
- Sits between the ALU's operand-issue stages and the writeback path.

Parameters:
- WIDTH, 32, operand and result width in bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 transfer accepted this cycle.
- req0_op  input  2  op code: 00 AND, 01 OR, 10 XOR, 11 NOR.
- req0_x  input  WIDTH  operand x.
- req0_y  input  WIDTH  operand y.
- req1_valid, req1_ready, req1_op, req1_x, req1_y: same as requester 0, for requester 1.
- res_valid  output  1  output register holds a result.
- res_ready  input  1  consumer accepts the result this cycle.
- res_data  output  WIDTH  result.
- res_id  output  1  index of the requester that produced res_data.
- res_zero  output  1  present only with LU_ZERO_FLAG_EN; high when res_data == 0.

Behaviour:
- Reset (rst=1 at a clock edge):
  - res_valid=0, res_data=0, res_id=0, res_zero=0.
  - Round-robin pointer last=1, so requester 0 wins the first tie.
  - Any held result is discarded. No req*_ready is asserted in the reset cycle.
- Output register state is EMPTY (res_valid=0) or FULL (res_valid=1).
- can_accept = !res_valid || res_ready (combinational).
- Grant (combinational):
  - Only req0_valid high: grant 0.
  - Only req1_valid high: grant 1.
  - Both high: grant the requester != last.
  - Neither high: no grant.
- reqN_ready = can_accept && (grant == N). At most one ready per cycle.
- ready may depend combinationally on valid; a requester must not wait for ready before raising valid.
- Transfer occurs on a cycle with reqN_valid && reqN_ready. At the next edge:
  - res_data = op(x, y), computed bitwise over all WIDTH bits.
  - res_id = N, res_valid = 1, last = N.
- The pointer changes only on an accepted transfer. Stalled ties keep the same winner.
- Consumer handshake:
  - res_valid && res_ready with no new transfer: res_valid goes to 0 next edge. res_data and res_id hold their values.
  - Result consumed and a new transfer in the same cycle: register reloads, res_valid stays 1. Full throughput is one op per cycle.
  - res_valid && !res_ready: res_data, res_id and res_zero stay stable. Both reqN_ready stay low.
- Latency: one cycle from accepted request to res_valid.
- Fairness: a requester held continuously valid is accepted within 2 consecutive accepted transfers.
- Requesters must hold x, y and op stable while valid && !ready. Behaviour with changing operands is undefined.
- All op codes are defined. There is no illegal-op state.

Optional Feature:
- Macro: LU_ZERO_FLAG_EN.
- Defined:
  - res_zero port exists and is registered alongside res_data.
  - res_zero = (op result == 0), computed from the result being loaded, not the stale register.
  - Reset value 0.
- Not defined: res_zero port and its register are absent. All other behaviour is identical.

Test Plan:
- Reset then single request:
  - Stimulus: rst 1 for 2 cycles; then req0 op=10, x=0xFFFF0000, y=0x0F0F0F0F; res_ready=1.
  - Response: req0_ready=1 that cycle. Next cycle res_valid=1, res_data=0xF0F00F0F, res_id=0.
- Tie and alternation:
  - Stimulus: both valid every cycle. req0 op=00, x=y=0xAAAAAAAA. req1 op=11, x=0, y=0. res_ready=1.
  - Response: results alternate id 0 (0xAAAAAAAA), id 1 (0xFFFFFFFF), id 0, ...; first winner is req0.
- Backpressure:
  - Stimulus: res_ready=0 for 3 cycles with req1 valid (op=01, x=0x1, y=0x2).
  - Response: req1 accepted once, res_data=0x00000003 held stable, req1_ready low for 3 cycles. On res_ready=1, the next req1 is accepted in the same cycle.
- Stalled tie keeps winner:
  - Stimulus: last=0, output FULL, res_ready=0, both valid for 4 cycles.
  - Response: when res_ready rises, req1 is granted.
- Reset mid-operation:
  - Stimulus: res_valid=1 with pending result; assert rst 1 cycle.
  - Response: res_valid=0, res_data=0. Next tie goes to req0.
- Zero flag (LU_ZERO_FLAG_EN):
  - Stimulus: op=10, x=y=0x12345678.
  - Response: res_data=0, res_zero=1. A following op=01 with x=0, y=0x1 gives res_zero=0.
